edge_detect_multi: RTL
======================

// Module: edge_detect_multi
// PURPOSE
// - Parametrised successor to the single-bit change-detect FSM: WIDTH independent channels, each
//   detecting rising, falling or both edges per a run-time mode, with programmable output pulse
//   stretch, retrigger, and sticky per-channel event flags with clear.
// - Sits between raw level inputs (buttons, status lines) and control logic that needs pulses or latched events.
// PARAMETERS
// - WIDTH    default 4   number of independent channels (>=1)
// - STRETCH  default 1   output pulse length in clk cycles per qualifying edge (>=1; 1 = single-cycle pulse)
// PORTS
// - clk      input   1        system clock; all logic on posedge clk
// - rst      input   1        reset, synchronous, active-high
// - in       input   WIDTH    level inputs, one bit per channel
// - mode     input   2        edge select, all channels: 00 off, 01 rise, 10 fall, 11 both
// - clr      input   WIDTH    per-channel sticky-flag clear, sampled each cycle
// - out      output  WIDTH    registered edge pulse per channel, stretched to STRETCH cycles
// - flag     output  WIDTH    registered sticky event flag per channel
// - evt_any  output  1        registered OR of flag, same-cycle as flag
// BEHAVIOUR
// - Reset: synchronous active-high on posedge clk; out=0, flag=0, evt_any=0, prev=0, all counters=0,
//   all channel FSMs IDLE. Reset mid-pulse aborts the pulse; out=0 from the cycle after rst sampled.
// - Per channel i: prev[i] <= s[i] each cycle (s = detected input, see CONFIGURATION).
//   rise = s & ~prev; fall = ~s & prev; hit = (mode[0]&rise)|(mode[1]&fall). First cycle after reset
//   compares against prev=0, so an input already high counts as a rise.
// - Channel FSM, two states: IDLE (out=0) and PULSE (out=1, cnt counts down).
//   IDLE  & hit       -> PULSE, cnt<=STRETCH-1.
//   PULSE & hit       -> PULSE, cnt<=STRETCH-1 (retrigger, pulse extended, no gap).
//   PULSE & cnt==0 & ~hit -> IDLE.  PULSE otherwise -> cnt<=cnt-1.
// - Latency: edge sampled at clk edge k -> out high on cycles k+1..k+STRETCH (retrigger extends).
// - cnt width = max(1,$clog2(STRETCH)); STRETCH=1 gives exactly one-cycle pulses, back-to-back
//   edges on consecutive cycles give continuous high out.
// - flag[i]: set on hit, cleared by clr[i]; hit & clr same cycle -> flag stays/becomes 1 (set wins).
// - evt_any <= |(next flag); updates same cycle as flag.
// - mode change: applies to hits sampled from the next clk edge; in-progress pulses run to completion.
//   mode=00: no new hits; flags hold; pulses finish.
// - Channels fully independent; no cross-channel priority or arbitration.
// CONFIGURATION
// - Macro EDGE_DETECT_SYNC_EN defined: each in bit passes through a 2-flop synchroniser (reset 0)
//   before detection; s = sync2 output; total latency in -> out = 3 cycles; safe for async inputs.
// - Macro undefined: s = in directly; latency in -> out = 1 cycle; in must be synchronous to clk.
// TESTING (latencies below without EDGE_DETECT_SYNC_EN; add 2 cycles with it)
// - Reset: rst=1 two cycles with in=4'hF -> out=0, flag=0, evt_any=0; release with in=4'hF, mode=01
//   -> out=4'hF one cycle later (rise vs prev=0), flag=4'hF.
// - WIDTH=4, STRETCH=3, mode=01: in[0] 0->1 at cycle 10 -> out[0]=1 cycles 11-13, 0 at 14;
//   in[0] 1->0 -> no pulse; flag[0]=1, evt_any=1.
// - mode=11, STRETCH=3: in[1] rises cycle 20, falls cycle 22 -> out[1]=1 cycles 21-25 continuous (retrigger).
// - mode=10: in[2] 1->0 -> one stretched pulse on out[2]; rise ignored; mode=00 mid-pulse -> pulse completes, no new hits.
// - Flags: clr[3]=1 same cycle as hit on ch3 -> flag[3]=1; clr[3]=1 alone next cycle -> flag[3]=0,
//   evt_any=0 if no other flag set.
// - Reset mid-pulse: rst=1 during out[0]=1 -> out=0, flag=0 next cycle; no pulse resumes after release if in steady low.

Source files
------------

// File: rtl/edge_detect_multi_if.sv
// Bundle of the edge detector's level inputs, controls and pulse/flag outputs.
// master drives inputs and controls; slave is the detector side.
interface edge_detect_multi_if #(
  parameter int WIDTH = 4
);
  logic [WIDTH-1:0] in;
  logic [1:0]       mode;
  logic [WIDTH-1:0] clr;
  logic [WIDTH-1:0] out;
  logic [WIDTH-1:0] flag;
  logic             evt_any;

  modport master (output in, mode, clr, input out, flag, evt_any);
  modport slave  (input in, mode, clr, output out, flag, evt_any);
endinterface

// File: rtl/edge_detect_multi.sv
// WIDTH-channel edge detector with stretched pulses, retrigger and sticky flags.
// Optional EDGE_DETECT_SYNC_EN adds a 2-flop synchroniser in front of each channel.
//
// state | meaning
// IDLE  | out low, waiting for a qualifying edge
// PULSE | out high, cnt counts remaining extra cycles down to 0
module edge_detect_multi #(
  parameter int WIDTH   = 4,
  parameter int STRETCH = 1
) (
  input  logic               clk,
  input  logic               rst,
  edge_detect_multi_if.slave bus
);
  localparam int CW = (STRETCH > 1) ? $clog2(STRETCH) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(STRETCH - 1);
  localparam logic IDLE  = 1'b0;
  localparam logic PULSE = 1'b1;

  logic [WIDTH-1:0]         s;
  logic [WIDTH-1:0]         prev;
  logic [WIDTH-1:0]         hit;
  logic [WIDTH-1:0]         state, state_nxt;
  logic [WIDTH-1:0][CW-1:0] cnt, cnt_nxt;
  logic [WIDTH-1:0]         flag_q, flag_nxt;
  logic                     evt_q;
  logic [WIDTH-1:0]         out_d;

`ifdef EDGE_DETECT_SYNC_EN
  logic [WIDTH-1:0] sync1, sync2;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= bus.in;
      sync2 <= sync1;
    end
  end

  assign s = sync2;
`else
  assign s = bus.in;
`endif

  assign hit = ({WIDTH{bus.mode[0]}} & s & ~prev) |
               ({WIDTH{bus.mode[1]}} & ~s & prev);

  // Set wins over clear when both land in the same cycle.
  assign flag_nxt = (flag_q & ~bus.clr) | hit;

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= {WIDTH{IDLE}};
      cnt    <= '0;
      prev   <= '0;
      flag_q <= '0;
      evt_q  <= 1'b0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      prev   <= s;
      flag_q <= flag_nxt;
      evt_q  <= |flag_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    for (int i = 0; i < WIDTH; i++) begin
      case (state[i])
        IDLE: begin
          if (hit[i]) begin
            state_nxt[i] = PULSE;
            cnt_nxt[i]   = CNT_LOAD;
          end
        end
        default: begin
          if (hit[i]) begin
            cnt_nxt[i] = CNT_LOAD;
          end else if (cnt[i] == '0) begin
            state_nxt[i] = IDLE;
          end else begin
            cnt_nxt[i] = cnt[i] - CW'(1);
          end
        end
      endcase
    end
  end

  always_comb begin
    out_d = '0;
    for (int i = 0; i < WIDTH; i++) begin
      out_d[i] = (state[i] == PULSE);
    end
  end

  assign bus.out     = out_d;
  assign bus.flag    = flag_q;
  assign bus.evt_any = evt_q;
endmodule
